// File: rtl/r5fp_dump_tx.sv
// r5fp_dump_tx: serializes FP check records into "DUMP: a b z flags\n" hex lines; R5FP_DUMP_SKID_EN adds a one-record skid buffer
module r5fp_dump_tx #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+SIG_W:0] in_a,
    input  logic [EXP_W+SIG_W:0] in_b,
    input  logic [EXP_W+SIG_W:0] in_z,
    input  logic [4:0]           in_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy
);
    localparam int W = EXP_W + SIG_W + 1;
    localparam int ND = (W + 3) / 4;
    localparam int CW = $clog2((ND > 6 ? ND : 6) + 1);
    localparam logic [47:0] PFX_STR = "DUMP: ";
    typedef enum logic [3:0] {IDLE, PFX, FA, S1, FB, S2, FZ, S3, FF, NL} state_t;
    state_t state, nState;
    logic [CW-1:0] cnt, nCnt, len;
    logic [W-1:0] recA, recB, recZ, nA, nB, nZ, srcA, srcB, srcZ;
    logic [4:0] recF, nF, srcF;
    logic [4*ND-1:0] field;
    logic [3:0] digit;
    logic [7:0] nData, pfxByte, hexByte;
    logic accept, xfer, last, leaveNl, loadWork, skidFull, nSkidFull;
    assign accept = in_valid && in_ready;
    assign xfer = out_valid && out_ready;
    assign leaveNl = xfer && state == NL;
    assign busy = (state != IDLE) || skidFull;
`ifdef R5FP_DUMP_SKID_EN
    logic [W-1:0] skA, skB, skZ;
    logic [4:0] skF;
    assign in_ready = !reset && !skidFull;
    // a record arriving on the NL edge with the skid empty goes straight to the working register
    assign loadWork = (accept && state == IDLE) || (leaveNl && (skidFull || accept));
    assign {srcA, srcB, srcZ, srcF} = skidFull ? {skA, skB, skZ, skF} : {in_a, in_b, in_z, in_flags};
    assign nSkidFull = skidFull ? !leaveNl : (accept && state != IDLE && !leaveNl);
    always_ff @(posedge clk) begin
        if (accept && !skidFull) {skA, skB, skZ, skF} <= {in_a, in_b, in_z, in_flags};
    end
`else
    assign in_ready = (state == IDLE) && !reset;
    assign loadWork = accept && state == IDLE;
    assign {srcA, srcB, srcZ, srcF} = {in_a, in_b, in_z, in_flags};
    assign nSkidFull = 1'b0;
`endif
    always_comb begin
        len = state == PFX ? CW'(6) :
              (state == FA || state == FB || state == FZ) ? CW'(ND) :
              state == FF ? CW'(2) : CW'(1);
        last = cnt == len - CW'(1);
        nState = state;
        nCnt = cnt;
        if (state == IDLE) begin
            nState = accept ? PFX : IDLE;
            nCnt = '0;
        end else if (xfer) begin
            nCnt = last ? '0 : cnt + CW'(1);
            if (last) nState = state == NL ? (loadWork ? PFX : IDLE) : state_t'(state + 4'd1);
        end
        {nA, nB, nZ, nF} = loadWork ? {srcA, srcB, srcZ, srcF} : {recA, recB, recZ, recF};
    end
    // out_data is precomputed from the next state so the registered byte lines up with the FSM
    always_comb begin
        field = nState == FA ? (4*ND)'(nA) : nState == FB ? (4*ND)'(nB) : (4*ND)'(nZ);
        digit = nState == FF ? 4'({3'b000, nF} >> (4 * (1 - int'(nCnt))))
                             : 4'(field >> (4 * (ND - 1 - int'(nCnt))));
        hexByte = digit < 4'd10 ? 8'h30 + {4'h0, digit} : 8'h57 + {4'h0, digit};
        pfxByte = 8'(PFX_STR >> (8 * (5 - int'(nCnt))));
        nData = nState == IDLE ? 8'h00 :
                nState == PFX ? pfxByte :
                (nState == S1 || nState == S2 || nState == S3) ? 8'h20 :
                nState == NL ? 8'h0a : hexByte;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            out_valid <= 1'b0;
            out_data <= 8'h00;
            skidFull <= 1'b0;
        end else begin
            state <= nState;
            cnt <= nCnt;
            out_valid <= nState != IDLE;
            out_data <= nData;
            skidFull <= nSkidFull;
        end
    end
    always_ff @(posedge clk) begin
        {recA, recB, recZ, recF} <= {nA, nB, nZ, nF};
    end
endmodule
